toff_mux_rr: RTL and testbench
==============================

Name: toff_mux_rr

Overview:
Parametrised N-channel, W-bit registered multiplexer with valid/ready handshakes on every input and on the output. The datapath is a log2(N)-level tree of toff_mux Toffoli 2:1 mux cells, instantiated per bit with ports (S, a0, a1, Y). A one-stage output register sits after the tree. Select source is either an external fixed select or an internal round-robin arbiter. It succeeds the single-bit combinational toff_mux in the reversible-logic datapath.

Parameters:
W, 8, data width per channel in bits (>=1)
N, 4, channel count (power of two, >=2)
SW, $clog2(N), select/pointer width (derived; do not override)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, synchronous, active-high
mode  in  1  0 = fixed select via sel; 1 = round-robin
sel  in  SW  channel index used when mode=0
in_data  in  N*W  channel i occupies bits [i*W +: W]
in_valid  in  N  per-channel valid
in_ready  out  N  per-channel ready; one-hot or zero
out_data  out  W  registered selected data
out_sel  out  SW  index of the channel held in the output register
out_valid  out  1  output register holds data
out_ready  in  1  downstream accepts

Behaviour:
- Reset (rst=1 at a clk edge): out_valid=0, out_data=0, out_sel=0, rr_ptr=0. in_ready=0 while rst=1. rst has priority over every other event, including a transfer in the same cycle; any in-flight word is dropped.
- load_en = !out_valid || out_ready (combinational). Back-to-back transfers are allowed, giving 1 word/cycle.
- Grant, mode=0: grant = sel if in_valid[sel]=1; otherwise no grant.
- Grant, mode=1: grant = first i with in_valid[i]=1, scanning rr_ptr, rr_ptr+1, ..., wrapping modulo N; no grant if in_valid=0.
- in_ready[i] = load_en && grant==i && !rst. All other in_ready bits are 0. in_ready is combinational from in_valid, mode, sel, rr_ptr and out_valid/out_ready.
- Transfer on channel g (in_valid[g] && in_ready[g]) at a clk edge:
  - out_data <= in_data[g*W +: W], out_sel <= g, out_valid <= 1.
  - rr_ptr <= (g+1) mod N in both modes.
- Latency: input transfer at edge k gives out_valid=1 and data from edge k. That is 1 cycle from acceptance.
- Output accepted (out_valid && out_ready) with no new grant: out_valid <= 0. out_data and out_sel hold their last value.
- Stall (out_valid=1, out_ready=0): out_data, out_sel and out_valid are held stable. in_ready stays all 0.
- Mode or sel changes take effect combinationally for the next arbitration and never disturb the output register. rr_ptr is retained across mode changes.
- in_valid may drop without a transfer; no state changes.
- Datapath: bit b of the tree output is selected by grant bits, LSB at the first level. The tree is purely combinational before the register. No other logic in the data path.

Optional Feature:
Macro TOFF_MUX_RR_PARITY_EN.
- Defined:
  - Adds output out_par (1 bit), registered alongside out_data on every transfer: out_par <= ^in_data[g*W +: W] (even parity, XOR of the W bits).
  - out_par resets to 0 and is held during stalls.
- Undefined: the out_par port and its register do not exist; all other behaviour is identical.

Test Plan:
1. Reset and idle:
   - Stimulus: rst=1 for 2 cycles with in_valid=4'b1111, then rst=0 with out_ready=0.
   - Response: in_ready=0 during reset; out_valid=0, out_data=0, out_sel=0 after reset. First edge after reset loads ch0 (rr_ptr=0, mode=1).
2. Fixed mode:
   - Stimulus: mode=0, sel=2, in_data ch2=8'hA5, in_valid=4'b0100, out_ready=1.
   - Response: in_ready=4'b0100; next cycle out_valid=1, out_data=8'hA5, out_sel=2.
   - Then sel=3 with in_valid[3]=0 -> in_ready=0, and out_valid falls after one cycle.
3. Round-robin fairness:
   - Stimulus: mode=1, in_valid=4'b1111 held, ch i data = 8'h10+i, out_ready=1.
   - Response: out_sel sequence 0,1,2,3,0 on consecutive cycles; out_data 10,11,12,13,10.
4. Backpressure:
   - Stimulus: out_valid=1 holding 8'h11, out_ready=0 for 3 cycles.
   - Response: out_data=8'h11 stable and in_ready=0 throughout.
   - Raising out_ready gives a transfer the same cycle and a new word on the next edge, with no bubble.
5. Reset mid-operation:
   - Stimulus: rst=1 on the same edge as a ch1 transfer.
   - Response: out_valid=0, rr_ptr=0, no word emitted; the following grant starts at ch0.
6. Parity (TOFF_MUX_RR_PARITY_EN defined): transfer 8'h07 -> out_par=1; transfer 8'h03 -> out_par=0.

Source files
------------

// File: rtl/toff_mux_rr.sv
// N-channel, W-bit registered mux over a Toffoli 2:1 cell tree, fixed or round-robin select.
// Optional even-parity output register enabled by TOFF_MUX_RR_PARITY_EN.

module toff_mux (
   input  logic S,
   input  logic a0,
   input  logic a1,
   output logic Y
);
   // Toffoli form: target a0 toggled by S AND (a0 ^ a1)
   assign Y = a0 ^ (S & (a0 ^ a1));
endmodule

module toff_mux_rr #(
   parameter int unsigned W  = 8,
   parameter int unsigned N  = 4,
   parameter int unsigned SW = $clog2(N)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            mode,
   input  logic [SW-1:0]   sel,
   input  logic [N*W-1:0]  in_data,
   input  logic [N-1:0]    in_valid,
   output logic [N-1:0]    in_ready,
   output logic [W-1:0]    out_data,
   output logic [SW-1:0]   out_sel,
   output logic            out_valid,
`ifdef TOFF_MUX_RR_PARITY_EN
   output logic            out_par,
`endif
   input  logic            out_ready
);

   logic [SW-1:0] rr_ptr;
   logic [SW-1:0] grant;
   logic [SW-1:0] scan_idx;
   logic          grant_vld;
   logic          load_en;
   logic          xfer;
   logic [W-1:0]  tree_out;

   assign load_en = !out_valid || out_ready;
   assign xfer    = grant_vld && load_en && !rst;

   // Arbitration: fixed select, or first valid channel scanning up from rr_ptr
   always_comb begin
      grant     = sel;
      grant_vld = 1'b0;
      scan_idx  = '0;
      if (!mode) begin
         grant     = sel;
         grant_vld = in_valid[sel];
      end else begin
         for (int k = 0; k < int'(N); k++) begin
            scan_idx = rr_ptr + SW'(k);
            if (!grant_vld && in_valid[scan_idx]) begin
               grant     = scan_idx;
               grant_vld = 1'b1;
            end
         end
      end
   end

   always_comb begin
      in_ready = '0;
      if (xfer) begin
         in_ready[grant] = 1'b1;
      end
   end

   // Heap-ordered tree: node 1 is the root, leaves N..2N-1 are channels 0..N-1
   logic [W-1:0] node [1:2*N-1];

   for (genvar i = 0; i < int'(N); i++) begin : g_leaf
      assign node[N+i] = in_data[i*W +: W];
   end

   // Depth d node switches on grant bit SW-1-d, so the leaf level uses the LSB
   for (genvar n = 1; n < int'(N); n++) begin : g_node
      localparam int unsigned LB = SW - $clog2(n + 1);
      for (genvar b = 0; b < int'(W); b++) begin : g_bit
         toff_mux u_cell (
            .S  (grant[LB]),
            .a0 (node[2*n][b]),
            .a1 (node[2*n+1][b]),
            .Y  (node[n][b])
         );
      end
   end

   assign tree_out = node[1];

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_sel   <= '0;
         rr_ptr    <= '0;
      end else if (xfer) begin
         out_valid <= 1'b1;
         out_data  <= tree_out;
         out_sel   <= grant;
         rr_ptr    <= SW'(grant + SW'(1));
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

`ifdef TOFF_MUX_RR_PARITY_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         out_par <= 1'b0;
      end else if (xfer) begin
         out_par <= ^tree_out;
      end
   end
`endif

endmodule

// File: tb/tb_toff_mux_rr.sv
// Table-driven bench for toff_mux_rr with a scoreboard of accepted words.
// Parity checks follow TOFF_MUX_RR_PARITY_EN.

module tb_toff_mux_rr;
   localparam int unsigned W  = 8;
   localparam int unsigned N  = 4;
   localparam int unsigned SW = 2;
   localparam logic [31:0] DEF = 32'h13121110;

   logic            clk = 1'b0;
   logic            rst;
   logic            mode;
   logic [SW-1:0]   sel;
   logic [N*W-1:0]  in_data;
   logic [N-1:0]    in_valid;
   logic [N-1:0]    in_ready;
   logic [W-1:0]    out_data;
   logic [SW-1:0]   out_sel;
   logic            out_valid;
   logic            out_ready;
`ifdef TOFF_MUX_RR_PARITY_EN
   logic            out_par;
`endif

   always #5 clk = ~clk;

   toff_mux_rr #(.W(W), .N(N)) dut (
      .clk       (clk),
      .rst       (rst),
      .mode      (mode),
      .sel       (sel),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_sel   (out_sel),
      .out_valid (out_valid),
`ifdef TOFF_MUX_RR_PARITY_EN
      .out_par   (out_par),
`endif
      .out_ready (out_ready)
   );

   typedef struct {
      logic        rst;
      logic        mode;
      logic [1:0]  sel;
      logic [3:0]  iv;
      logic [31:0] data;
      logic        ordy;
      logic [3:0]  exp_rdy;
      logic        exp_vld;
   } vec_t;

   typedef struct {
      logic [7:0] d;
      logic [1:0] s;
   } exp_t;

   vec_t vecs[$];
   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;
   logic [7:0] hold_d;
   logic [1:0] hold_s;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   function automatic void add(input logic r, input logic m, input logic [1:0] s,
                               input logic [3:0] iv, input logic [31:0] d, input logic o,
                               input logic [3:0] er, input logic ev);
      vec_t v;
      v = '{r, m, s, iv, d, o, er, ev};
      vecs.push_back(v);
   endfunction

   task automatic check_outputs(input string tag);
      chk({tag, ".out_data"}, 32'(out_data), 32'(hold_d));
      chk({tag, ".out_sel"},  32'(out_sel),  32'(hold_s));
`ifdef TOFF_MUX_RR_PARITY_EN
      chk({tag, ".out_par"},  32'(out_par),  32'(^hold_d));
`endif
   endtask

   initial begin
      exp_t e;
      int   g;
      int   n;

      rst = 1'b1; mode = 1'b1; sel = '0; in_valid = 4'hF; in_data = DEF; out_ready = 1'b0;
      hold_d = '0; hold_s = '0;

      //   rst mode sel  iv       data                    ordy  exp_rdy  exp_vld
      add(1, 1, 0, 4'b1111, DEF,          0, 4'b0000, 0);  // reset with all valid
      add(1, 1, 0, 4'b1111, DEF,          0, 4'b0000, 0);
      add(0, 1, 0, 4'b1111, DEF,          0, 4'b0001, 1);  // first grant ch0
      add(0, 1, 0, 4'b1111, DEF,          0, 4'b0000, 1);  // stall
      add(0, 0, 2, 4'b0100, 32'h13A51110, 1, 4'b0100, 1);  // fixed sel=2
      add(0, 0, 3, 4'b0100, DEF,          1, 4'b0000, 0);  // sel=3 not valid
      add(0, 1, 0, 4'b1111, DEF,          1, 4'b1000, 1);  // rr_ptr=3
      add(0, 1, 0, 4'b1111, DEF,          1, 4'b0001, 1);  // fairness 0,1,2,3,0
      add(0, 1, 0, 4'b1111, DEF,          1, 4'b0010, 1);
      add(0, 1, 0, 4'b1111, DEF,          1, 4'b0100, 1);
      add(0, 1, 0, 4'b1111, DEF,          1, 4'b1000, 1);
      add(0, 1, 0, 4'b1111, DEF,          1, 4'b0001, 1);
      add(0, 1, 0, 4'b1111, DEF,          1, 4'b0010, 1);  // load 8'h11
      add(0, 1, 0, 4'b1111, DEF,          0, 4'b0000, 1);  // backpressure x3
      add(0, 1, 0, 4'b1111, DEF,          0, 4'b0000, 1);
      add(0, 1, 0, 4'b1111, DEF,          0, 4'b0000, 1);
      add(0, 1, 0, 4'b1111, DEF,          1, 4'b0100, 1);  // release, no bubble
      add(0, 1, 0, 4'b0000, DEF,          1, 4'b0000, 0);  // drain
      add(1, 1, 0, 4'b0010, DEF,          1, 4'b0000, 0);  // reset vs ch1 transfer
      add(0, 1, 0, 4'b1111, DEF,          1, 4'b0001, 1);  // restarts at ch0
      add(0, 1, 0, 4'b1001, DEF,          1, 4'b1000, 1);  // skip idle channels
      add(0, 1, 0, 4'b0110, DEF,          1, 4'b0010, 1);  // wrap to ch1
      add(0, 0, 0, 4'b0110, DEF,          1, 4'b0000, 0);  // fixed sel on idle ch
      add(0, 0, 1, 4'b1111, DEF,          0, 4'b0010, 1);  // empty reg loads w/o ready
      add(0, 1, 0, 4'b0001, 32'h13121107, 0, 4'b0000, 1);  // stall, mode change
      add(0, 1, 0, 4'b0001, 32'h13121107, 1, 4'b0001, 1);  // 8'h07, parity 1
      add(0, 0, 2, 4'b0100, 32'h13031110, 1, 4'b0100, 1);  // 8'h03, parity 0

      foreach (vecs[i]) begin
         rst = vecs[i].rst; mode = vecs[i].mode; sel = vecs[i].sel;
         in_valid = vecs[i].iv; in_data = vecs[i].data; out_ready = vecs[i].ordy;
         @(negedge clk);
         chk($sformatf("v%0d.in_ready", i), 32'(in_ready), 32'(vecs[i].exp_rdy));
         if (vecs[i].exp_rdy != 4'b0000) begin
            g = 0;
            for (int c = 0; c < 4; c++) if (vecs[i].exp_rdy[c]) g = c;
            e.d = vecs[i].data[g*8 +: 8];
            e.s = 2'(g);
            sb.push_back(e);
         end
         @(posedge clk); #1;
         if (vecs[i].rst) begin
            hold_d = '0; hold_s = '0;
            sb.delete();
         end else if (vecs[i].exp_rdy != 4'b0000) begin
            if (sb.size() == 0) begin
               chk($sformatf("v%0d.scoreboard", i), 32'd0, 32'd1);
            end else begin
               e = sb.pop_front();
               hold_d = e.d; hold_s = e.s;
            end
         end
         chk($sformatf("v%0d.out_valid", i), 32'(out_valid), 32'(vecs[i].exp_vld));
         check_outputs($sformatf("v%0d", i));
      end

      // Reset coinciding with an offered ch1 transfer; grant must restart at ch0
      rst = 1'b1; mode = 1'b1; in_valid = 4'b0010; in_data = DEF; out_ready = 1'b1;
      @(negedge clk);
      chk("mid_rst.in_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0; in_valid = 4'b1111;
      hold_d = '0; hold_s = '0;
      chk("mid_rst.out_valid", 32'(out_valid), 32'd0);
      check_outputs("mid_rst");
      n = 0;
      @(negedge clk);
      while (in_ready == 4'b0000 && n < 5) begin
         n++;
         @(negedge clk);
      end
      chk("mid_rst.first_grant", 32'(in_ready), 32'b0001);
      @(posedge clk); #1;
      hold_d = 8'h10; hold_s = 2'd0;
      chk("mid_rst.out_valid1", 32'(out_valid), 32'd1);
      check_outputs("mid_rst.word");
      @(negedge clk);
      chk("mid_rst.next_grant", 32'(in_ready), 32'b0010);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
